// File: rtl/irq_responder.sv
// irq_responder: CPU-side responder for the interrupt controller's
// IRQ / IACK / isr_addr handshake.
//
// Waits for an instruction boundary (retire) while a request is armed,
// saves the return PC and vector, acknowledges the controller for
// ACK_CYCLES cycles, then redirects fetch to the ISR. An mret in
// SERVICE redirects back to the saved PC and restores mie.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   IRQ, isr_addr     level request and vector from the controller
//   IACK              acknowledge to the controller
//   retire, next_pc   instruction boundary pulse and next sequential PC
//   mret              return-from-interrupt retired
//   ie_set, ie_clr    global enable control (clear wins)
//   redirect(_pc)     one-cycle fetch redirect and its target
//   epc               saved return PC (top of stack when nesting)
//   in_isr, mie       servicing flag and global interrupt enable
//   bad_ret           mret seen outside SERVICE
//
// Build option: define IRQ_NEST_EN for a NEST_DEPTH-entry saved-PC
// stack that lets SERVICE re-arm on a new request.
module irq_responder #(
   parameter int ADDR_W     = 32,
   parameter int ACK_CYCLES = 1,
   parameter int NEST_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IRQ,
   input  logic [ADDR_W-1:0] isr_addr,
   output logic              IACK,
   input  logic              retire,
   input  logic [ADDR_W-1:0] next_pc,
   input  logic              mret,
   input  logic              ie_set,
   input  logic              ie_clr,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] epc,
   output logic              in_isr,
   output logic              mie,
   output logic              bad_ret
);

   if (ACK_CYCLES < 1 || ACK_CYCLES > 4) begin : g_bad_ack
      $error("irq_responder: ACK_CYCLES must be 1..4");
   end
   if (NEST_DEPTH < 1) begin : g_bad_depth
      $error("irq_responder: NEST_DEPTH must be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      ACK,
      JUMP,
      SERVICE
   } state_t;

   localparam logic [1:0] ACK_LAST = 2'(ACK_CYCLES - 1);

   state_t            state_q, state_d;
   logic [1:0]        ack_cnt_q, ack_cnt_d;
   logic [ADDR_W-1:0] vec_q, vec_d;
   logic              mie_q, mie_d;
   logic              in_isr_q, in_isr_d;
   logic              iack_q, iack_d;
   logic              redirect_q, redirect_d;
   logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
   logic              bad_ret_q, bad_ret_d;
   logic              ie_next;

   // save / restore requests towards the return-state storage
   logic              push;
   logic              pop;

   // views of the return-state storage
   logic [ADDR_W-1:0] top_epc;
   logic              top_mpie;
   logic              last_level;
   logic              nest_arm;
   logic              nested;

`ifdef IRQ_NEST_EN
   localparam int PTR_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
   localparam int DEP_W = $clog2(NEST_DEPTH + 1);

   logic [ADDR_W-1:0]     epc_stk [NEST_DEPTH];
   logic [NEST_DEPTH-1:0] mpie_stk;
   logic [DEP_W-1:0]      depth_q;
   logic [PTR_W-1:0]      push_ptr;
   logic [PTR_W-1:0]      top_ptr;
   logic                  full;

   assign push_ptr   = PTR_W'(depth_q);
   // at depth 0 the bottom entry stays visible as the last return PC
   assign top_ptr    = (depth_q == '0) ? '0 : PTR_W'(depth_q - 1'b1);
   assign full       = (depth_q == DEP_W'(NEST_DEPTH));
   assign top_epc    = epc_stk[top_ptr];
   assign top_mpie   = mpie_stk[top_ptr];
   assign last_level = (depth_q == DEP_W'(1));
   assign nested     = (depth_q != '0);
   assign nest_arm   = IRQ & mie_q & ~full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NEST_DEPTH; i++) begin
            epc_stk[i] <= '0;
         end
         mpie_stk <= '0;
         depth_q  <= '0;
      end else if (push) begin
         epc_stk[push_ptr]  <= next_pc;
         mpie_stk[push_ptr] <= mie_q;
         depth_q            <= depth_q + 1'b1;
      end else if (pop) begin
         depth_q <= depth_q - 1'b1;
      end
   end
`else
   logic [ADDR_W-1:0] epc_q;
   logic              mpie_q;

   assign top_epc    = epc_q;
   assign top_mpie   = mpie_q;
   assign last_level = 1'b1;
   assign nested     = 1'b0;
   assign nest_arm   = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_q  <= '0;
         mpie_q <= 1'b0;
      end else if (push) begin
         epc_q  <= next_pc;
         mpie_q <= mie_q;
      end
   end

   // pop needs no storage action with a single return slot
   logic unused_pop;
   assign unused_pop = pop;
`endif

   always_comb begin
      if (ie_clr) begin
         ie_next = 1'b0;
      end else if (ie_set) begin
         ie_next = 1'b1;
      end else begin
         ie_next = mie_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      ack_cnt_d     = ack_cnt_q;
      vec_d         = vec_q;
      mie_d         = mie_q;
      in_isr_d      = in_isr_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      bad_ret_d     = mret & (state_q != SERVICE);
      push          = 1'b0;
      pop           = 1'b0;

      unique case (state_q)
         IDLE: begin
            mie_d = ie_next;
            if (IRQ && mie_q && !in_isr_q) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            mie_d = ie_next;
            // a dropped request or a disabled mie abandons the entry
            if (!IRQ || !mie_q || ie_clr) begin
               state_d = nested ? SERVICE : IDLE;
            end else if (retire) begin
               vec_d     = isr_addr;
               mie_d     = 1'b0;
               push      = 1'b1;
               ack_cnt_d = '0;
               state_d   = ACK;
            end
         end
         ACK: begin
            if (ack_cnt_q == ACK_LAST) begin
               state_d       = JUMP;
               redirect_d    = 1'b1;
               redirect_pc_d = vec_q;
               in_isr_d      = 1'b1;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end
         JUMP: begin
            state_d = SERVICE;
         end
         SERVICE: begin
            mie_d = ie_next;
            if (mret) begin
               redirect_d    = 1'b1;
               redirect_pc_d = top_epc;
               mie_d         = top_mpie;
               pop           = 1'b1;
               if (last_level) begin
                  in_isr_d = 1'b0;
                  state_d  = IDLE;
               end
            end else if (nest_arm) begin
               state_d = ARMED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      iack_d = (state_d == ACK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ack_cnt_q     <= '0;
         vec_q         <= '0;
         mie_q         <= 1'b0;
         in_isr_q      <= 1'b0;
         iack_q        <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         bad_ret_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ack_cnt_q     <= ack_cnt_d;
         vec_q         <= vec_d;
         mie_q         <= mie_d;
         in_isr_q      <= in_isr_d;
         iack_q        <= iack_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         bad_ret_q     <= bad_ret_d;
      end
   end

   assign IACK        = iack_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign epc         = top_epc;
   assign in_isr      = in_isr_q;
   assign mie         = mie_q;
   assign bad_ret     = bad_ret_q;

endmodule

// File: tb/tb_irq_responder.sv
// tb_irq_responder: directed + randomized bench for irq_responder
// with a queue-based model of saved return state.
module tb_irq_responder;

   localparam int AW  = 32;
   localparam int ACK = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, IRQ, retire, mret, ie_set, ie_clr;
   logic [AW-1:0] isr_addr, next_pc;
   logic          IACK, redirect, in_isr, mie, bad_ret;
   logic [AW-1:0] redirect_pc, epc;

   logic          rst3_n, IRQ3, retire3, mret3, ie_set3, ie_clr3;
   logic [AW-1:0] isr3, next3;
   logic          IACK3, redirect3, in_isr3, mie3, bad_ret3;
   logic [AW-1:0] redirect_pc3, epc3;

   irq_responder #(.ADDR_W(AW), .ACK_CYCLES(ACK), .NEST_DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .IRQ(IRQ), .isr_addr(isr_addr),
      .IACK(IACK), .retire(retire), .next_pc(next_pc), .mret(mret),
      .ie_set(ie_set), .ie_clr(ie_clr), .redirect(redirect),
      .redirect_pc(redirect_pc), .epc(epc), .in_isr(in_isr),
      .mie(mie), .bad_ret(bad_ret)
   );

   irq_responder #(.ADDR_W(AW), .ACK_CYCLES(3), .NEST_DEPTH(4)) u_dut3 (
      .clk(clk), .rst_n(rst3_n), .IRQ(IRQ3), .isr_addr(isr3),
      .IACK(IACK3), .retire(retire3), .next_pc(next3), .mret(mret3),
      .ie_set(ie_set3), .ie_clr(ie_clr3), .redirect(redirect3),
      .redirect_pc(redirect_pc3), .epc(epc3), .in_isr(in_isr3),
      .mie(mie3), .bad_ret(bad_ret3)
   );

   int total = 0;
   int bad   = 0;

   // architectural model: enable bit plus a stack of {return PC, mpie}
   bit            m_mie;
   logic [31:0]   m_base;
   logic [31:0]   q_pc[$];
   bit            q_mpie[$];

   function automatic logic [31:0] exp_epc();
      return (q_pc.size() != 0) ? q_pc[$] : m_base;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ie(input logic s, input logic c);
      ie_set = s;
      ie_clr = c;
      tick();
      ie_set = 1'b0;
      ie_clr = 1'b0;
      m_mie = c ? 1'b0 : (s ? 1'b1 : m_mie);
      chk1("mie_ctl", mie, m_mie);
   endtask

   task automatic enter(input logic [31:0] vec, input logic [31:0] pc,
                        input int waits);
      IRQ = 1'b1;
      isr_addr = vec;
      tick();
      for (int i = 0; i < waits; i++) begin
         tick();
         chk1("armed_no_iack", IACK, 1'b0);
      end
      retire = 1'b1;
      next_pc = pc;
      tick();
      retire = 1'b0;
      isr_addr = $urandom;
      for (int c = 1; c <= ACK; c++) begin
         chk1("iack_on", IACK, 1'b1);
         chk1("no_redir_in_ack", redirect, 1'b0);
         IRQ = 1'b0;
         tick();
      end
      if (q_pc.size() == 0) m_base = pc;
      q_pc.push_back(pc);
      q_mpie.push_back(m_mie);
      m_mie = 1'b0;
      chk1("iack_off", IACK, 1'b0);
      chk1("redir_isr", redirect, 1'b1);
      chkv("redir_isr_pc", redirect_pc, vec);
      chk1("in_isr_jump", in_isr, 1'b1);
      chkv("epc_saved", epc, pc);
      chk1("mie_entry", mie, 1'b0);
      tick();
      chk1("redir_pulse_end", redirect, 1'b0);
      chk1("in_isr_svc", in_isr, 1'b1);
   endtask

   task automatic leave(input logic with_retire);
      logic [31:0] exp_pc;
      bit          exp_mie;
      mret = 1'b1;
      retire = with_retire;
      next_pc = $urandom;
      tick();
      mret = 1'b0;
      retire = 1'b0;
      exp_pc = q_pc[$];
      exp_mie = q_mpie[$];
      void'(q_pc.pop_back());
      void'(q_mpie.pop_back());
      m_mie = exp_mie;
      chk1("ret_redir", redirect, 1'b1);
      chkv("ret_pc", redirect_pc, exp_pc);
      chk1("ret_mie", mie, m_mie);
      chk1("ret_in_isr", in_isr, q_pc.size() != 0);
      chk1("ret_no_bad", bad_ret, 1'b0);
      chkv("ret_epc", epc, exp_epc());
      tick();
      chk1("ret_pulse_end", redirect, 1'b0);
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk1("quiet_iack", IACK, 1'b0);
         chk1("quiet_redir", redirect, 1'b0);
      end
      chkv("quiet_epc", epc, exp_epc());
   endtask

   task automatic spur_before(input int w);
      IRQ = 1'b1;
      isr_addr = $urandom;
      tick();
      for (int i = 0; i < w; i++) tick();
      IRQ = 1'b0;
      tick();
      retire = 1'b1;
      next_pc = $urandom;
      tick();
      retire = 1'b0;
      chk1("spur_iack", IACK, 1'b0);
      quiet(3);
   endtask

   task automatic spur_same();
      IRQ = 1'b1;
      isr_addr = $urandom;
      tick();
      IRQ = 1'b0;
      retire = 1'b1;
      next_pc = $urandom;
      tick();
      retire = 1'b0;
      chk1("spur_same_iack", IACK, 1'b0);
      quiet(3);
   endtask

   task automatic isr_body(input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 4))
            1: set_ie(1'b1, 1'b0);
            2: set_ie(1'b0, 1'b1);
            3: set_ie(1'b1, 1'b1);
            4: begin
               retire = 1'b1;
               next_pc = $urandom;
               tick();
               retire = 1'b0;
               chk1("body_in_isr", in_isr, 1'b1);
            end
            default: tick();
         endcase
      end
   endtask

   task automatic reset_main();
      rst_n = 1'b0;
      q_pc.delete();
      q_mpie.delete();
      m_mie = 1'b0;
      m_base = '0;
      tick();
      tick();
      chk1("rst_iack", IACK, 1'b0);
      chk1("rst_redir", redirect, 1'b0);
      chkv("rst_redir_pc", redirect_pc, 32'h0);
      chkv("rst_epc", epc, 32'h0);
      chk1("rst_in_isr", in_isr, 1'b0);
      chk1("rst_mie", mie, 1'b0);
      chk1("rst_bad_ret", bad_ret, 1'b0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic arm3();
      rst3_n = 1'b0;
      tick();
      rst3_n = 1'b1;
      tick();
      ie_set3 = 1'b1;
      tick();
      ie_set3 = 1'b0;
      chk1("d3_mie", mie3, 1'b1);
      IRQ3 = 1'b1;
      isr3 = 32'h0005_0000;
      tick();
      retire3 = 1'b1;
      next3 = 32'h0000_0208;
      tick();
      retire3 = 1'b0;
   endtask

   initial begin
      int          n_ack;
      int          rc;
      int          first;
      logic [31:0] v;
      logic [31:0] p;

      rst_n = 1'b0;
      IRQ = 1'b0; retire = 1'b0; mret = 1'b0;
      ie_set = 1'b0; ie_clr = 1'b0;
      isr_addr = '0; next_pc = '0;
      rst3_n = 1'b0;
      IRQ3 = 1'b0; retire3 = 1'b0; mret3 = 1'b0;
      ie_set3 = 1'b0; ie_clr3 = 1'b0;
      isr3 = '0; next3 = '0;

      reset_main();

      // basic entry and return
      set_ie(1'b1, 1'b0);
      enter(32'h0004_0000, 32'h0000_0104, 0);
      leave(1'b0);
      quiet(3);

      // spurious requests
      spur_before(2);
      spur_same();

      // masked request held for 20 cycles
      set_ie(1'b0, 1'b1);
      IRQ = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (IACK) n_ack++;
      end
      chkv("masked_iack_count", n_ack, 0);
      IRQ = 1'b0;
      tick();

      // mret outside an ISR
      mret = 1'b1;
      tick();
      mret = 1'b0;
      chk1("bad_ret_pulse", bad_ret, 1'b1);
      chk1("bad_ret_no_redir", redirect, 1'b0);
      tick();
      chk1("bad_ret_end", bad_ret, 1'b0);

      // clear wins over set
      set_ie(1'b1, 1'b0);
      set_ie(1'b1, 1'b1);
      chk1("set_clr_mie", mie, 1'b0);

      // clearing mie while armed abandons the entry
      set_ie(1'b1, 1'b0);
      IRQ = 1'b1;
      tick();
      set_ie(1'b0, 1'b1);
      retire = 1'b1;
      tick();
      retire = 1'b0;
      chk1("armed_clr_iack", IACK, 1'b0);
      IRQ = 1'b0;
      quiet(2);

      // randomized scenarios
      for (int it = 0; it < 24; it++) begin
         if (!m_mie) set_ie(1'b1, 1'b0);
         v = $urandom;
         p = $urandom;
         case ($urandom_range(0, 3))
            0, 1: begin
               enter(v, p, $urandom_range(0, 3));
               isr_body($urandom_range(0, 4));
               leave(1'($urandom_range(0, 1)));
            end
            2: spur_before($urandom_range(0, 3));
            default: spur_same();
         endcase
      end

`ifdef IRQ_NEST_EN
      reset_main();
      set_ie(1'b1, 1'b0);
      enter(32'h0003_0000, 32'h0000_0104, 1);
      set_ie(1'b1, 1'b0);
      enter(32'h0006_0000, 32'h0003_0020, 0);
      chkv("nest_epc_top", epc, 32'h0003_0020);
      leave(1'b0);
      chkv("nest_epc_after_pop", epc, 32'h0000_0104);
      chk1("nest_still_isr", in_isr, 1'b1);
      leave(1'b0);
      chk1("nest_done", in_isr, 1'b0);

      set_ie(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         enter(32'h0001_0000 * (i + 1), 32'h0000_0200 + i * 4, 0);
         set_ie(1'b1, 1'b0);
      end
      IRQ = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            retire = 1'b1;
         end
         tick();
         retire = 1'b0;
         if (IACK) n_ack++;
      end
      chkv("full_iack_count", n_ack, 0);
      IRQ = 1'b0;
      for (int i = 0; i < 4; i++) leave(1'b0);
      chk1("full_unwound", in_isr, 1'b0);
`endif

      // ACK_CYCLES=3: count the acknowledge window
      arm3();
      n_ack = 0;
      rc = -1;
      first = -1;
      for (int c = 1; c <= 7; c++) begin
         if (IACK3) begin
            n_ack++;
            if (first < 0) first = c;
         end
         if (redirect3 && rc < 0) rc = c;
         IRQ3 = 1'b0;
         isr3 = $urandom;
         tick();
      end
      chkv("d3_iack_cycles", n_ack, 3);
      chkv("d3_iack_first", first, 1);
      chkv("d3_redir_cycle", rc, 4);
      chkv("d3_redir_pc", redirect_pc3, 32'h0005_0000);
      chkv("d3_epc", epc3, 32'h0000_0208);

      // ACK_CYCLES=3: reset during the second acknowledge cycle
      arm3();
      chk1("d3_ack1", IACK3, 1'b1);
      tick();
      chk1("d3_ack2", IACK3, 1'b1);
      #1 rst3_n = 1'b0;
      #1;
      chk1("d3_rst_iack", IACK3, 1'b0);
      chk1("d3_rst_redir", redirect3, 1'b0);
      chkv("d3_rst_redir_pc", redirect_pc3, 32'h0);
      chkv("d3_rst_epc", epc3, 32'h0);
      chk1("d3_rst_in_isr", in_isr3, 1'b0);
      chk1("d3_rst_mie", mie3, 1'b0);
      chk1("d3_rst_bad_ret", bad_ret3, 1'b0);
      IRQ3 = 1'b0;
      tick();
      rst3_n = 1'b1;
      tick();
      tick();
      chk1("d3_post_rst_iack", IACK3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
